// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Shares one single-port synchronous word RAM between a
//                read-only instruction-fetch port (i_*) and a read/write
//                load/store port (d_*). The grant is combinational in the
//                request cycle, and the one-cycle-latency read data is routed
//                back to whichever port won. A streak counter guarantees that
//                fetch makes progress under sustained data traffic.
//  Ports       : sys_clk/sys_rst       - clock, synchronous active-high reset
//                i_req/i_addr/i_flush  - fetch request, address, redirect
//                i_gnt/i_rvalid/i_rdata- fetch grant and response
//                d_req/d_we/d_be/d_addr/d_wdata - load/store request
//                d_gnt/d_rvalid/d_rdata- data grant and response
//                mem_en/mem_we/mem_addr/mem_wdata/mem_rdata - RAM port
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W          = 32,
    parameter int IDX_W           = 12,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    // instruction-fetch port
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    input  logic              i_flush,
    output logic              i_rvalid,
    output logic [31:0]       i_rdata,
    // load/store port
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_be,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    // RAM port
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [IDX_W-1:0]  mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);
    localparam logic [STREAK_W-1:0] C_STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

    typedef enum logic [1:0] {
        OWN_NONE    = 2'd0,
        OWN_FETCH   = 2'd1,
        OWN_DATA_RD = 2'd2,
        OWN_DATA_WR = 2'd3
    } owner_t;

    owner_t              owner_q, owner_d;
    logic [STREAK_W-1:0] streak_q, streak_d;

    logic w_i_gnt;
    logic w_d_gnt;
    logic w_fetch_prio;

    // Only the word-index bits of the addresses reach the RAM; the rest are
    // intentionally dropped so addresses wrap modulo the RAM size.
    logic w_unused;
    assign w_unused = ^{i_addr, d_addr};

    // ------------------------------------------------------------------
    // Arbitration and RAM request mux
    // ------------------------------------------------------------------
    always_comb begin
        w_fetch_prio = (streak_q == C_STREAK_MAX);

        // Data wins by default; fetch only wins on a full streak, and a
        // redirecting fetch is never granted. If a flush blocks a prioritised
        // fetch, data may still use the idle slot.
        w_i_gnt = ~sys_rst & i_req & ~i_flush & (~d_req | w_fetch_prio);
        w_d_gnt = ~sys_rst & d_req & ~w_i_gnt;

        mem_en    = w_i_gnt | w_d_gnt;
        mem_we    = 4'd0;
        mem_addr  = '0;
        mem_wdata = 32'd0;
        if (w_i_gnt) begin
            mem_addr = i_addr[IDX_W+1:2];
        end else if (w_d_gnt) begin
            mem_addr  = d_addr[IDX_W+1:2];
            mem_wdata = d_wdata;
            mem_we    = d_we ? d_be : 4'd0;
        end

        i_gnt = w_i_gnt;
        d_gnt = w_d_gnt;
    end

    // ------------------------------------------------------------------
    // Next-state: streak counter and response owner
    // ------------------------------------------------------------------
    always_comb begin
        streak_d = streak_q;
        owner_d  = OWN_NONE;

        if (w_i_gnt || !i_req) begin
            streak_d = '0;
        end else if (w_d_gnt && !i_flush && (streak_q != C_STREAK_MAX)) begin
            streak_d = streak_q + 1'b1;
        end

        if (w_i_gnt) begin
            owner_d = OWN_FETCH;
        end else if (w_d_gnt) begin
            owner_d = d_we ? OWN_DATA_WR : OWN_DATA_RD;
        end

        if (sys_rst) begin
            streak_d = '0;
            owner_d  = OWN_NONE;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            streak_q <= '0;
            owner_q  <= OWN_NONE;
        end else begin
            streak_q <= streak_d;
            owner_q  <= owner_d;
        end
    end

    // ------------------------------------------------------------------
    // Response routing. Reset also masks a response already in flight,
    // and a flush discards a fetch response in the cycle it would appear.
    // ------------------------------------------------------------------
    always_comb begin
        i_rvalid = ~sys_rst & ~i_flush & (owner_q == OWN_FETCH);
        d_rvalid = ~sys_rst & ((owner_q == OWN_DATA_RD) || (owner_q == OWN_DATA_WR));
        i_rdata  = i_rvalid ? mem_rdata : 32'd0;
        d_rdata  = (d_rvalid && (owner_q == OWN_DATA_RD)) ? mem_rdata : 32'd0;
    end

endmodule
`default_nettype wire
